instr_fetch_queue: RTL and testbench

//  Fetch stage placed ahead of the decode pipeline register. Owns the fetch PC, issues in-order

---
 rtl/instr_fetch_queue_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 51 +++++
 rtl/instr_fetch_queue.sv | 119 +++++++++++
 tb/tb_instr_fetch_queue.sv | 486 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_queue_pkg.sv
// Shared fetch-stage definitions: widths, reset PC default, NOP word and the queue entry type.
// The optional FETCH_BYPASS_EN macro is consumed by instr_fetch_queue.sv.
package instr_fetch_queue_pkg;

  localparam int unsigned     XLEN             = 32;
  localparam logic [XLEN-1:0] INSTR_BYTES      = 32'd4;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] pc_align(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer with head/tail pointers wrapping mod DEPTH, synchronous clear and async reset.
// Used both for the {pc,instr} prefetch queue and for the in-flight PC tag queue.
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_clear,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [PW:0]      r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_tail <= r_tail + PW'(1);
      if (i_pop)  r_head <= r_head + PW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push && !i_clear) r_mem[r_tail] <= i_data;
  end

  assign o_head  = r_mem[r_head];
  assign o_count = r_count;

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: owns the fetch PC, issues in-order imem requests, buffers words and flushes on redirect.
// Define FETCH_BYPASS_EN to forward a response straight to decode when the queue is empty.
module instr_fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr_out,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus4_out,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc
);

  localparam int unsigned CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0] CREDITS = (CW+1)'(DEPTH);

  logic [XLEN-1:0] r_fetch_pc;
  logic [CW-1:0]   r_kill;
  logic            r_active;

  logic [CW-1:0]   w_count;
  logic [CW-1:0]   w_inflight;
  logic [CW:0]     w_used;
  logic            w_req_fire;
  logic            w_resp_accept;
  logic            w_resp_live;
  logic            w_bypass;
  logic            w_have;
  logic            w_push;
  logic            w_pop;
  logic [XLEN-1:0] w_resp_pc;
  fetch_entry_t    w_head;
  fetch_entry_t    w_resp_entry;
  fetch_entry_t    w_out;

  // Buffered plus in-flight words never exceed DEPTH, so the queue cannot overflow.
  assign w_used         = {1'b0, w_count} + {1'b0, w_inflight};
  assign imem_req_valid = r_active & ~redirect & (w_used < CREDITS);
  assign imem_req_addr  = r_fetch_pc;
  assign w_req_fire     = imem_req_valid & imem_req_ready;

  // Every accepted response retires its tag, even when it is discarded as wrong-path.
  assign w_resp_accept = imem_resp_valid & (w_inflight != '0);
  assign w_resp_live   = w_resp_accept & (r_kill == '0) & ~redirect;
  assign w_resp_entry  = '{pc: w_resp_pc, instr: imem_resp_data};
  assign w_have        = (w_count != '0);

`ifdef FETCH_BYPASS_EN
  assign w_bypass = w_resp_live & ~w_have;
`else
  assign w_bypass = 1'b0;
`endif

  assign instr_valid  = ~redirect & (w_have | w_bypass);
  assign w_out        = w_have ? w_head : w_resp_entry;
  assign w_pop        = instr_valid & instr_ready & w_have;
  assign w_push       = w_resp_live & ~(w_bypass & instr_ready);
  assign instr_out    = instr_valid ? w_out.instr : '0;
  assign pc_out       = instr_valid ? w_out.pc : '0;
  assign pc_plus4_out = pc_out + INSTR_BYTES;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_kill     <= '0;
      r_active   <= 1'b0;
    end else begin
      r_active <= 1'b1;
      if (redirect) begin
        r_fetch_pc <= pc_align(redirect_pc);
        r_kill     <= w_inflight - CW'(w_resp_accept);
      end else begin
        if (w_req_fire) r_fetch_pc <= r_fetch_pc + INSTR_BYTES;
        if (w_resp_accept && (r_kill != '0)) r_kill <= r_kill - CW'(1);
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2 * XLEN)
  ) u_data_fifo (
    .i_clk   (clk),
    .i_rst   (reset),
    .i_clear (redirect),
    .i_push  (w_push),
    .i_data  (w_resp_entry),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count)
  );

  // Tags are never flushed: killed responses still return and must retire theirs.
  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (XLEN)
  ) u_tag_fifo (
    .i_clk   (clk),
    .i_rst   (reset),
    .i_clear (1'b0),
    .i_push  (w_req_fire),
    .i_data  (r_fetch_pc),
    .i_pop   (w_resp_accept),
    .o_head  (w_resp_pc),
    .o_count (w_inflight)
  );

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: in-order memory model plus expected-instruction queue.
// Honours FETCH_BYPASS_EN for the response-to-decode latency check.
module tb_instr_fetch_queue;
  import instr_fetch_queue_pkg::*;

  localparam int unsigned DEPTH = 4;
`ifdef FETCH_BYPASS_EN
  localparam int LAT_EXP = 1;
`else
  localparam int LAT_EXP = 2;
`endif

  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
  typedef struct { logic [31:0] addr; int unsigned due; } pend_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b1;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4_out;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned lat = 1;
  int unsigned n_fire = 0;
  int unsigned mcyc = 0;
  logic [31:0] exp_pc;
  exp_t        sb[$];
  pend_t       pend[$];

  instr_fetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr_out       (instr_out),
    .pc_out          (pc_out),
    .pc_plus4_out    (pc_plus4_out),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ NOP_INSTR;
  endfunction

  // Memory model with fixed latency; expected entries follow the bench's own PC model.
  initial begin : model
    logic        fire;
    logic [31:0] faddr;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    exp_pc          = 32'h0;
    forever begin
      @(negedge clk);
      fire  = imem_req_valid & imem_req_ready;
      faddr = imem_req_addr;
      if (redirect) begin
        sb.delete();
        exp_pc = redirect_pc & 32'hFFFF_FFFC;
      end
      if (fire && !reset) begin
        sb.push_back('{pc: exp_pc, instr: mem_word(exp_pc)});
        exp_pc = exp_pc + 32'd4;
        n_fire++;
      end
      @(posedge clk);
      #1;
      mcyc++;
      if (reset) begin
        pend.delete();
        sb.delete();
        exp_pc          = 32'h0;
        n_fire          = 0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
      end else begin
        if (fire) pend.push_back('{addr: faddr, due: mcyc + lat - 1});
        if (pend.size() != 0 && pend[0].due <= mcyc) begin
          imem_resp_valid = 1'b1;
          imem_resp_data  = mem_word(pend[0].addr);
          void'(pend.pop_front());
        end else begin
          imem_resp_valid = 1'b0;
          imem_resp_data  = '0;
        end
      end
    end
  end

  task automatic do_reset(input int unsigned l, input logic rdy);
    @(posedge clk);
    #2;
    reset       = 1'b1;
    redirect    = 1'b0;
    instr_ready = rdy;
    @(posedge clk);
    #2;
    lat = l;
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  task automatic drive_redirect(input logic [31:0] tgt);
    @(posedge clk);
    #1;
    redirect    = 1'b1;
    redirect_pc = tgt;
    @(posedge clk);
    #1;
    redirect = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    n_cmp++;
    if (imem_req_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_req_valid: got %b want 0", imem_req_valid);
    end
    n_cmp++;
    if (instr_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_instr_valid: got %b want 0", instr_valid);
    end
    n_cmp++;
    if ({instr_out, pc_out} !== 64'h0) begin
      n_err++;
      $display("FAIL reset_outputs: instr=%h pc=%h want 0/0", instr_out, pc_out);
    end
    n_cmp++;
    if (pc_plus4_out !== 32'h4) begin
      n_err++;
      $display("FAIL reset_pc_plus4: got %h want 00000004", pc_plus4_out);
    end
  endtask

  task automatic test_basic;
    int   fire_at = -1;
    int   valid_at = -1;
    int   last_c = -1;
    int   seen = 0;
    exp_t e;
    do_reset(1, 1'b1);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #1;
      if (fire_at < 0 && imem_req_valid && imem_req_ready) fire_at = c;
      if (instr_valid && instr_ready) begin
        if (valid_at < 0) valid_at = c;
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL basic_order: unexpected pc=%h, none expected", pc_out);
        end else begin
          e = sb.pop_front();
          if ({instr_out, pc_out, pc_plus4_out} !== {e.instr, e.pc, e.pc + 32'd4}) begin
            n_err++;
            $display("FAIL basic_order: got %h/%h/%h want %h/%h/%h", instr_out, pc_out,
                     pc_plus4_out, e.instr, e.pc, e.pc + 32'd4);
          end
        end
        if (seen > 0 && seen < 4) begin
          n_cmp++;
          if (c != last_c + 1) begin
            n_err++;
            $display("FAIL basic_consecutive: gap at cycle %0d want %0d", c, last_c + 1);
          end
        end
        last_c = c;
        seen++;
      end
    end
    n_cmp++;
    if (fire_at < 0 || valid_at < 0 || (valid_at - fire_at) != LAT_EXP) begin
      n_err++;
      $display("FAIL basic_latency: fire@%0d valid@%0d want distance %0d", fire_at, valid_at,
               LAT_EXP);
    end
  endtask

  task automatic test_stall;
    logic [31:0] got_pc[5];
    logic [31:0] want_pc[5];
    logic [31:0] held;
    bit          moved = 1'b0;
    int          popped = 0;
    exp_t        e;
    want_pc = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    do_reset(1, 1'b0);
    repeat (10) @(negedge clk);
    #1;
    n_cmp++;
    if (imem_req_valid !== 1'b0) begin
      n_err++;
      $display("FAIL stall_req_valid: got %b want 0", imem_req_valid);
    end
    n_cmp++;
    if (n_fire != DEPTH) begin
      n_err++;
      $display("FAIL stall_outstanding: got %0d requests want %0d", n_fire, DEPTH);
    end
    n_cmp++;
    if (instr_valid !== 1'b1 || pc_out !== 32'h0 || instr_out !== mem_word(32'h0)) begin
      n_err++;
      $display("FAIL stall_head: valid=%b pc=%h instr=%h want 1/0/%h", instr_valid, pc_out,
               instr_out, mem_word(32'h0));
    end
    held = pc_out;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      if (pc_out !== held || instr_valid !== 1'b1) moved = 1'b1;
    end
    n_cmp++;
    if (moved) begin
      n_err++;
      $display("FAIL stall_hold: head changed, now pc=%h want %h", pc_out, held);
    end
    @(posedge clk);
    #1;
    instr_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      #1;
      if (instr_valid && instr_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL stall_order: unexpected pc=%h, none expected", pc_out);
        end else begin
          e = sb.pop_front();
          if ({instr_out, pc_out} !== {e.instr, e.pc}) begin
            n_err++;
            $display("FAIL stall_order: got %h/%h want %h/%h", instr_out, pc_out, e.instr, e.pc);
          end
        end
        if (popped < 5) got_pc[popped] = pc_out;
        popped++;
      end
    end
    n_cmp++;
    if (popped < 5 || got_pc != want_pc) begin
      n_err++;
      $display("FAIL stall_release: %0d popped, first pcs %h %h %h %h %h want 0 4 8 c 10",
               popped, got_pc[0], got_pc[1], got_pc[2], got_pc[3], got_pc[4]);
    end
  endtask

  task automatic test_redirect;
    int   waited = 0;
    bit   first = 1'b1;
    exp_t e;
    do_reset(3, 1'b1);
    while (n_fire < 2 && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    drive_redirect(32'h0000_0104);
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      #1;
      if (instr_valid && instr_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL redir_order: unexpected pc=%h, none expected", pc_out);
        end else begin
          e = sb.pop_front();
          if ({instr_out, pc_out} !== {e.instr, e.pc}) begin
            n_err++;
            $display("FAIL redir_order: got %h/%h want %h/%h", instr_out, pc_out, e.instr, e.pc);
          end
        end
        if (first) begin
          first = 1'b0;
          n_cmp++;
          if (pc_out !== 32'h104 || pc_plus4_out !== 32'h108) begin
            n_err++;
            $display("FAIL redir_first: pc=%h pc4=%h want 00000104/00000108", pc_out,
                     pc_plus4_out);
          end
        end
      end
    end
    n_cmp++;
    if (first) begin
      n_err++;
      $display("FAIL redir_timeout: no instr_valid after redirect, want pc 00000104");
    end
  endtask

  task automatic test_redirect_align;
    logic [31:0] got[3];
    int          n;
    exp_t        e;
    do_reset(1, 1'b0);
    repeat (3) @(negedge clk);
    drive_redirect(32'h0000_0203);
    instr_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #1;
      if (instr_valid && instr_ready) begin
        if (sb.size() != 0) void'(sb.pop_front());
        if (n == 0) got[0] = pc_out;
        n++;
      end
    end
    n_cmp++;
    if (n == 0 || got[0] !== 32'h200) begin
      n_err++;
      $display("FAIL align_target: %0d outputs, first pc=%h want 00000200", n, got[0]);
    end
    drive_redirect(32'hFFFF_FFFC);
    n = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #1;
      if (instr_valid && instr_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL wrap_order: unexpected pc=%h, none expected", pc_out);
        end else begin
          e = sb.pop_front();
          if ({instr_out, pc_out} !== {e.instr, e.pc}) begin
            n_err++;
            $display("FAIL wrap_order: got %h/%h want %h/%h", instr_out, pc_out, e.instr, e.pc);
          end
        end
        if (n < 2) got[n] = pc_plus4_out;
        if (n == 0) got[2] = pc_out;
        n++;
      end
    end
    n_cmp++;
    if (n < 2 || got[2] !== 32'hFFFF_FFFC || got[0] !== 32'h0 || got[1] !== 32'h4) begin
      n_err++;
      $display("FAIL wrap_pc: pc=%h pc4=%h next pc4=%h want fffffffc/00000000/00000004",
               got[2], got[0], got[1]);
    end
  endtask

  task automatic test_push_pop;
    int   popped = 0;
    bit   over = 1'b0;
    exp_t e;
    do_reset(1, 1'b0);
    repeat (8) @(negedge clk);
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      instr_ready = (c < 24) ? (c % 2 == 0) : (c % 3 != 0);
      @(negedge clk);
      #1;
      if (instr_valid && instr_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL pushpop_order: unexpected pc=%h, none expected", pc_out);
        end else begin
          e = sb.pop_front();
          if ({instr_out, pc_out} !== {e.instr, e.pc}) begin
            n_err++;
            $display("FAIL pushpop_order: got %h/%h want %h/%h", instr_out, pc_out, e.instr,
                     e.pc);
          end
        end
        popped++;
      end
      if (sb.size() > DEPTH) over = 1'b1;
    end
    n_cmp++;
    if (over) begin
      n_err++;
      $display("FAIL pushpop_credit: more than %0d requests outstanding", DEPTH);
    end
    n_cmp++;
    if (popped + sb.size() != n_fire || popped < 10) begin
      n_err++;
      $display("FAIL pushpop_conserve: popped %0d + pending %0d, want %0d fetched (>=10 popped)",
               popped, sb.size(), n_fire);
    end
  endtask

  task automatic test_reset_mid;
    bit   first = 1'b1;
    exp_t e;
    do_reset(3, 1'b1);
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      #1;
      if (instr_valid && instr_ready && sb.size() != 0) void'(sb.pop_front());
    end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({imem_req_valid, instr_valid} !== 2'b00 || {instr_out, pc_out} !== 64'h0
        || pc_plus4_out !== 32'h4) begin
      n_err++;
      $display("FAIL midreset_outputs: req=%b valid=%b instr=%h pc=%h pc4=%h want 0/0/0/0/4",
               imem_req_valid, instr_valid, instr_out, pc_out, pc_plus4_out);
    end
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      #1;
      if (instr_valid && instr_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL midreset_order: unexpected pc=%h, none expected", pc_out);
        end else begin
          e = sb.pop_front();
          if ({instr_out, pc_out} !== {e.instr, e.pc}) begin
            n_err++;
            $display("FAIL midreset_order: got %h/%h want %h/%h", instr_out, pc_out, e.instr,
                     e.pc);
          end
        end
        if (first) begin
          first = 1'b0;
          n_cmp++;
          if (pc_out !== 32'h0 || instr_out !== mem_word(32'h0)) begin
            n_err++;
            $display("FAIL midreset_first: pc=%h instr=%h want 00000000/%h", pc_out, instr_out,
                     mem_word(32'h0));
          end
        end
      end
    end
    n_cmp++;
    if (first) begin
      n_err++;
      $display("FAIL midreset_timeout: no instr_valid after reset, want pc 00000000");
    end
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    test_reset();
    test_basic();
    test_stall();
    test_redirect();
    test_redirect_align();
    test_push_pop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
